// File: rtl/uart_tx_crc_if.sv
// Write-side bus of uart_tx_crc: byte strobe in, buffer-not-full status out.
// With UART_TX_CRC_EN defined the bus also carries wlast, the end-of-block marker.
interface uart_tx_crc_if;
    logic [7:0] wdata;
    logic       wr;
`ifdef UART_TX_CRC_EN
    logic       wlast;
`endif
    logic       tbnf;

`ifdef UART_TX_CRC_EN
    modport master (output wdata, output wr, output wlast, input tbnf);
    modport slave  (input wdata, input wr, input wlast, output tbnf);
`else
    modport master (output wdata, output wr, input tbnf);
    modport slave  (input wdata, input wr, output tbnf);
`endif
endinterface

// File: rtl/uart_tx_crc.sv
// Buffered 8N1 UART transmitter. Defining UART_TX_CRC_EN adds wlast and a
// CRC-8 (poly 0x07) trailer frame after every byte marked wlast.
module uart_tx_crc #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 4
) (
    input  logic         clk,
    input  logic         reset,
    uart_tx_crc_if.slave bus,
    output logic         txd,
    output logic         txi
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int BC_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_CRC_EN
    localparam int ENTRY_W = 9;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, CSTART, CDATA, CSTOP} state_t;
`else
    localparam int ENTRY_W = 8;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t             state_q, state_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [BC_W-1:0]    bitCnt_q, bitCnt_d;
    logic [2:0]         bitIdx_q, bitIdx_d;
    logic [7:0]         shift_q, shift_d;
    logic               txd_q, txd_d;
    logic               push, pop, boundary, frameDone;
    logic [ENTRY_W-1:0] head, wrEntry;

`ifdef UART_TX_CRC_EN
    logic [7:0] crc_q, crc_d;
    logic       last_q, last_d;

    function automatic logic [7:0] crc8(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    assign wrEntry = {bus.wlast, bus.wdata};
`else
    assign wrEntry = bus.wdata;
`endif

    // A full buffer still accepts a write when the transmitter pops in the same cycle.
    assign head     = mem_q[rdPtr_q];
    assign push     = bus.wr && ((count_q != CNT_W'(DEPTH)) || pop);
    assign bus.tbnf = (count_q < CNT_W'(DEPTH));
    assign txi      = (state_q == IDLE) && (count_q == '0);
    assign txd      = txd_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        bitCnt_d  = bitCnt_q;
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        frameDone = 1'b0;
`ifdef UART_TX_CRC_EN
        crc_d     = crc_q;
        last_d    = last_q;
`endif
        boundary  = (bitCnt_q == '0);
        if (state_q != IDLE) begin
            bitCnt_d = boundary ? BIT_LAST : bitCnt_q - BC_W'(1);
        end

        unique case (state_q)
            IDLE:  frameDone = 1'b1;
            START: if (boundary) begin
                state_d  = DATA;
                bitIdx_d = '0;
            end
            DATA:  if (boundary) begin
                shift_d  = shift_q >> 1;
                bitIdx_d = bitIdx_q + 3'd1;
                if (bitIdx_q == 3'd7) state_d = STOP;
            end
            STOP:  if (boundary) begin
`ifdef UART_TX_CRC_EN
                if (last_q) begin
                    state_d = CSTART;
                    shift_d = crc_q;
                    last_d  = 1'b0;
                end else
`endif
                frameDone = 1'b1;
            end
`ifdef UART_TX_CRC_EN
            CSTART: if (boundary) begin
                state_d  = CDATA;
                bitIdx_d = '0;
            end
            CDATA:  if (boundary) begin
                shift_d  = shift_q >> 1;
                bitIdx_d = bitIdx_q + 3'd1;
                if (bitIdx_q == 3'd7) state_d = CSTOP;
            end
            CSTOP:  if (boundary) begin
                crc_d     = '0;
                frameDone = 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase

        // End of a frame (or idle): start the next buffered byte with no gap.
        if (frameDone) begin
            if (count_q != '0) begin
                pop      = 1'b1;
                shift_d  = head[7:0];
                state_d  = START;
                bitCnt_d = BIT_LAST;
`ifdef UART_TX_CRC_EN
                last_d   = head[8];
                crc_d    = crc8(crc_d, head[7:0]);
`endif
            end else begin
                state_d  = IDLE;
                bitCnt_d = '0;
            end
        end
    end

    always_comb begin
        txd_d = 1'b1;
        unique case (state_q)
            START:  txd_d = 1'b0;
            DATA:   txd_d = shift_q[0];
`ifdef UART_TX_CRC_EN
            CSTART: txd_d = 1'b0;
            CDATA:  txd_d = shift_q[0];
`endif
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            bitCnt_q <= '0;
            bitIdx_q <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
`ifdef UART_TX_CRC_EN
            crc_q    <= '0;
            last_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            bitCnt_q <= bitCnt_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
`ifdef UART_TX_CRC_EN
            crc_q    <= crc_d;
            last_q   <= last_d;
`endif
            if (push) wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (pop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wrPtr_q] <= wrEntry;
    end
endmodule

// File: tb/tb_uart_tx_crc.sv
// Bench for uart_tx_crc: a frame-level line model plus a software UART receiver.
// CRC trailer tests are compiled only when UART_TX_CRC_EN is defined.
module tb_uart_tx_crc;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic txd, txi;
    int   checks = 0;
    int   errors = 0;

    uart_tx_crc_if bus();

    uart_tx_crc #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .txd   (txd),
        .txi   (txi)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Line model: queued bytes, then the exact per-cycle txd values still to come.
    logic [8:0] mq[$];
    bit         lineQ[$];
    int         rem     = 0;
    int         mFrames = 0;
    logic [7:0] mcrc    = 8'h00;
    bit         mpend   = 1'b0;
    logic       expTxd  = 1'b1;
    logic       expTxi  = 1'b1;
    logic       expTbnf = 1'b1;

    // CRC as polynomial long division of (crc ^ byte) * x^8 by x^8+x^2+x+1.
    function automatic logic [7:0] crcByte(input logic [7:0] crc, input logic [7:0] data);
        logic [15:0] v;
        v = {crc ^ data, 8'h00};
        for (int b = 15; b >= 8; b--) begin
            if (v[b]) v = v ^ (16'h0107 << (b - 8));
        end
        return v[7:0];
    endfunction

    task automatic appendFrame(input logic [7:0] d);
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < CPB; c++) begin
                lineQ.push_back((b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1]);
            end
        end
        rem = FRAME;
        mFrames++;
    endtask

    task automatic modelStep();
        logic       wrS;
        logic [8:0] entry;
        wrS      = bus.wr;
`ifdef UART_TX_CRC_EN
        entry    = {bus.wlast, bus.wdata};
`else
        entry    = {1'b0, bus.wdata};
`endif
        expTxd   = (lineQ.size() > 0) ? lineQ.pop_front() : 1'b1;
        if (rem > 0) rem--;
        if (rem == 0) begin
            if (mpend) begin
                appendFrame(mcrc);
                mcrc  = 8'h00;
                mpend = 1'b0;
            end else if (mq.size() > 0) begin
                logic [8:0] e;
                e = mq.pop_front();
                appendFrame(e[7:0]);
                mcrc = crcByte(mcrc, e[7:0]);
                if (e[8]) mpend = 1'b1;
            end
        end
        if (wrS && mq.size() < DEPTH) mq.push_back(entry);
        expTxi  = (rem == 0) && (mq.size() == 0) && !mpend;
        expTbnf = (mq.size() < DEPTH);
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            mq.delete();
            lineQ.delete();
            rem     = 0;
            mcrc    = 8'h00;
            mpend   = 1'b0;
            expTxd  = 1'b1;
            expTxi  = 1'b1;
            expTbnf = 1'b1;
        end else begin
            modelStep();
        end
    end

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            checkOutput("txd", txd, expTxd);
            checkOutput("txi", txi, expTxi);
            checkOutput("tbnf", bus.tbnf, expTbnf);
        end
    end

    // Software receiver: samples mid-bit and records each byte with its start cycle.
    logic [7:0] rxQ[$];
    int         rxStartQ[$];
    int         cyc = 0;
    bit         rxBusy = 1'b0;
    int         rxPos = 0;
    int         rxStart = 0;
    int         rxK = 0;
    logic [7:0] rxByte = 8'h00;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (reset) begin
            rxBusy = 1'b0;
        end else if (!rxBusy) begin
            if (txd === 1'b0) begin
                rxBusy  = 1'b1;
                rxPos   = 0;
                rxStart = cyc;
            end
        end else begin
            rxPos++;
            if (rxPos % CPB == CPB / 2) begin
                rxK = rxPos / CPB;
                if (rxK == 0) begin
                    if (txd !== 1'b0) rxBusy = 1'b0;
                end else if (rxK <= 8) begin
                    rxByte[rxK-1] = txd;
                end else begin
                    checkOutput("stopBit", txd, 1'b1);
                    rxQ.push_back(rxByte);
                    rxStartQ.push_back(rxStart);
                    rxBusy = 1'b0;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        while (bus.tbnf !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("tbnfWait", bus.tbnf, 1'b1);
        bus.wr    = 1'b1;
        bus.wdata = d;
`ifdef UART_TX_CRC_EN
        bus.wlast = l;
`else
        if (l) $display("[TB] wlast ignored in this build");
`endif
        @(negedge clk);
        bus.wr    = 1'b0;
`ifdef UART_TX_CRC_EN
        bus.wlast = 1'b0;
`endif
    endtask

    task automatic waitIdle(input int limit);
        int n;
        n = 0;
        while (txi !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idleReached", txi, 1'b1);
        repeat (CPB) @(negedge clk);
    endtask

    task automatic clearRx();
        rxQ.delete();
        rxStartQ.delete();
    endtask

    logic [9:0] patA5;
    logic [7:0] burst[6];
    logic [7:0] msg[9];
    int         framesBefore;

    initial begin
        bus.wr    = 1'b0;
        bus.wdata = 8'h00;
`ifdef UART_TX_CRC_EN
        bus.wlast = 1'b0;
`endif
        @(negedge clk);
        checkOutput("resetTxd", txd, 1'b1);
        checkOutput("resetTxi", txi, 1'b1);
        checkOutput("resetTbnf", bus.tbnf, 1'b1);
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);

        // Single 0xA5 frame: latency, exact bit pattern, return to idle.
        $display("[TB] single byte 0xA5");
        clearRx();
        patA5 = 10'b1101001010;
        bus.wr = 1'b1;
        bus.wdata = 8'hA5;
        @(negedge clk);
        bus.wr = 1'b0;
        @(negedge clk);
        checkOutput("latencyEdge1", txd, 1'b1);
        @(negedge clk);
        checkOutput("latencyEdge2", txd, 1'b0);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) repeat (CPB) @(negedge clk);
            checkOutput($sformatf("bitA5_%0d", k), txd, patA5[k]);
        end
        repeat (2) @(negedge clk);
        checkOutput("txiBusyEnd", txi, 1'b0);
        @(negedge clk);
        checkOutput("txiIdleAgain", txi, 1'b1);
        repeat (CPB) @(negedge clk);
        checkOutput("rxCountA5", rxQ.size(), 1);
        if (rxQ.size() > 0) checkOutput("rxByteA5", rxQ[0], 8'hA5);

        // Six writes on consecutive cycles: the sixth hits a full buffer.
        $display("[TB] burst of six");
        clearRx();
        for (int i = 0; i < 6; i++) begin
            burst[i]  = 8'($urandom);
            bus.wr    = 1'b1;
            bus.wdata = burst[i];
            if (i == 5) checkOutput("tbnfSixthWrite", bus.tbnf, 1'b0);
            @(negedge clk);
        end
        bus.wr = 1'b0;
        waitIdle(7 * FRAME);
        checkOutput("burstFrames", rxQ.size(), 5);
        for (int i = 0; i < 5 && i < rxQ.size(); i++) begin
            checkOutput($sformatf("burstByte%0d", i), rxQ[i], burst[i]);
            if (i > 0) checkOutput($sformatf("burstGap%0d", i), rxStartQ[i] - rxStartQ[i-1], FRAME);
        end

        // Full buffer: write 0x3C exactly on the cycle of the next pop.
        $display("[TB] write while full with pop");
        repeat (3) @(negedge clk);
        clearRx();
        for (int i = 0; i < 5; i++) begin
            burst[i]  = 8'($urandom);
            bus.wr    = 1'b1;
            bus.wdata = burst[i];
            @(negedge clk);
        end
        bus.wr = 1'b0;
        repeat (FRAME - 4) @(negedge clk);
        checkOutput("fullBefore3C", bus.tbnf, 1'b0);
        bus.wr    = 1'b1;
        bus.wdata = 8'h3C;
        @(negedge clk);
        bus.wr = 1'b0;
        checkOutput("fullAfter3C", bus.tbnf, 1'b0);
        waitIdle(7 * FRAME);
        checkOutput("fullFrames", rxQ.size(), 6);
        if (rxQ.size() == 6) begin
            for (int i = 0; i < 5; i++) checkOutput($sformatf("fullByte%0d", i), rxQ[i], burst[i]);
            checkOutput("lastIs3C", rxQ[5], 8'h3C);
        end

        // Asynchronous reset in the middle of a frame with bytes still buffered.
        $display("[TB] reset mid-frame");
        repeat (3) @(negedge clk);
        clearRx();
        for (int i = 0; i < 3; i++) begin
            bus.wr    = 1'b1;
            bus.wdata = 8'h00 + 8'(i * 17);
            @(negedge clk);
        end
        bus.wr = 1'b0;
        repeat (15) @(negedge clk);
        checkOutput("midFrameLow", txd, 1'b0);
        #2 reset = 1'b1;
        #1;
        checkOutput("asyncTxd", txd, 1'b1);
        checkOutput("asyncTxi", txi, 1'b1);
        checkOutput("asyncTbnf", bus.tbnf, 1'b1);
        bus.wr    = 1'b1;
        bus.wdata = 8'h5A;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.wr = 1'b0;
        waitIdle(3 * FRAME);
        checkOutput("postResetFrames", rxQ.size(), 1);
        if (rxQ.size() == 1) checkOutput("postResetByte", rxQ[0], 8'h5A);

        // Random traffic against the model, including writes into a full buffer.
        $display("[TB] random traffic");
        clearRx();
        framesBefore = mFrames;
        for (int i = 0; i < 400; i++) begin
            bus.wr    = ($urandom_range(0, 3) == 0);
            bus.wdata = 8'($urandom);
`ifdef UART_TX_CRC_EN
            bus.wlast = ($urandom_range(0, 3) == 0);
`endif
            @(negedge clk);
        end
        bus.wr = 1'b0;
`ifdef UART_TX_CRC_EN
        bus.wlast = 1'b0;
`endif
        waitIdle((2 * DEPTH + 4) * FRAME);
        checkOutput("randomFrames", rxQ.size(), mFrames - framesBefore);

`ifdef UART_TX_CRC_EN
        // CRC trailer over "123456789", then a one-byte block proving the clear.
        $display("[TB] crc blocks");
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        clearRx();
        for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
        for (int i = 0; i < 9; i++) applyStimulus(msg[i], i == 8);
        applyStimulus(8'h01, 1'b1);
        waitIdle(14 * FRAME);
        checkOutput("crcFrames", rxQ.size(), 12);
        if (rxQ.size() == 12) begin
            for (int i = 0; i < 9; i++) checkOutput($sformatf("crcMsg%0d", i), rxQ[i], msg[i]);
            checkOutput("crcCheckF4", rxQ[9], 8'hF4);
            checkOutput("crcByte01", rxQ[10], 8'h01);
            checkOutput("crcCleared07", rxQ[11], 8'h07);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        errors++;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/uart_tx_crc.md
UART_TX_CRC -- requirements
Module: uart_tx_crc

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit time, legal range 2..65535.
REQ-002 Parameter DEPTH, default 4: transmit buffer entries, power of two, minimum 2.
REQ-003 Port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port wdata  input  8  byte to enqueue.
REQ-006 Port wr  input  1  write strobe; wdata is sampled on posedge clk while wr=1.
REQ-007 Port wlast  input  1  marks the final byte of a CRC block; present only when UART_TX_CRC_EN is defined.
REQ-008 Port txd  output  1  serial line, registered, idle high.
REQ-009 Port txi  output  1  transmitter idle; feeds status register bit 4.
REQ-010 Port tbnf  output  1  transmit buffer not full; feeds status register bit 5.

Function
REQ-011 Buffer SHALL be a DEPTH-entry FIFO with wrap-around read/write pointers and an occupancy count of 0..DEPTH.
REQ-012 A write while full and no pop in the same cycle SHALL be discarded, with FIFO contents unchanged.
REQ-013 A write while full with a pop in the same cycle SHALL be accepted.
REQ-014 A simultaneous write and pop SHALL leave the count unchanged.
REQ-015 tbnf SHALL equal (count < DEPTH), computed from registered state.
REQ-016 txi SHALL be 1 only when the FSM is IDLE and count == 0.
REQ-017 FSM states: IDLE, START, DATA, STOP; under UART_TX_CRC_EN only, also CSTART, CDATA, CSTOP.
REQ-018 IDLE with count > 0: pop the head entry into the shift register and go to START, driving txd=0 from the next edge.
REQ-019 Latency: with the FSM IDLE and FIFO empty, txd SHALL go low on the second posedge after the edge that samples wr.
REQ-020 Each bit SHALL be held exactly CLKS_PER_BIT cycles, timed by a bit counter that reloads on every bit boundary.
REQ-021 Frame = start bit 0, 8 data bits LSB first, stop bit 1; total 10*CLKS_PER_BIT cycles.
REQ-022 At the end of STOP with count > 0, the next pop and START SHALL occur with no idle gap.
REQ-023 At the end of STOP with count == 0, the FSM SHALL go to IDLE and txd SHALL stay 1.
REQ-024 wdata SHALL be ignored when wr=0.
REQ-025 A byte already in the shift register SHALL NOT be affected by later writes.

Reset
REQ-026 Asserting reset SHALL immediately force: txd=1, txi=1, tbnf=1, FSM=IDLE, count=0, both pointers=0, bit counter=0, CRC=0x00.
REQ-027 Reset mid-frame SHALL abort the frame and discard all buffered bytes; no partial frame resumes after release.
REQ-028 After reset deasserts, the first posedge SHALL behave as a normal IDLE cycle.

Configuration
REQ-029 Macro UART_TX_CRC_EN: when defined, FIFO entries are 9 bits (wdata plus wlast), and a CRC-8 is accumulated over every transmitted data byte.
REQ-030 CRC-8 parameters: polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR.
REQ-031 After the STOP of a byte with wlast=1, the FSM SHALL send one extra frame carrying the CRC, via CSTART/CDATA/CSTOP with the same framing, and then clear the CRC to 0x00.
REQ-032 txi SHALL stay 0 until the CRC frame's stop bit has completed.
REQ-033 Buffered bytes SHALL wait until the CRC frame completes.
REQ-034 When UART_TX_CRC_EN is undefined: the wlast port, CRC logic and C* states are absent, and FIFO entries are 8 bits wide.

Verification (CLKS_PER_BIT=4, DEPTH=4)
REQ-035 Reset, then write 0xA5 -> txd low 2 edges after wr; line reads 0,1,0,1,0,0,1,0,1,1, each 4 cycles; txi returns to 1 after 40 cycles.
REQ-036 Write 6 bytes on consecutive cycles while idle -> first pops; 4 buffered; 6th discarded; tbnf=0 during the 6th write; exactly 5 back-to-back frames with no gap.
REQ-037 FIFO full; write 0x3C in the same cycle as the pop at a STOP end -> 0x3C accepted and transmitted last; tbnf stays 0.
REQ-038 Assert reset at cycle 15 of a frame -> txd=1 within the same cycle without a clock edge; txi=1, tbnf=1; no further frames.
REQ-039 (CRC_EN) Send ASCII "123456789" with wlast on '9' -> 10th frame carries 0xF4.
REQ-040 (CRC_EN) Follow with 0x01 with wlast=1 -> CRC frame 0x07, confirming the CRC was cleared.
